// File: rtl/memory.sv
// Memory stage of the RV32I pipeline, between Execute and Writeback.
// Holds one instruction, runs its load/store over a req/ack data bus
// (byte/half lane alignment, sign/zero extension), stalls upstream while
// the access is pending, and registers the completed result into Writeback.
// Bus handshake: dmem_req stays high with stable addr/we/be/wdata until the
// first cycle dmem_ack is high; that cycle completes the access, and ack may
// arrive in the same cycle req first rises.
module memory #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            execute_valid,
    input  logic [4:0]      execute_rd,
    input  logic            execute_rd_wr_en,
    input  logic [XLEN-1:0] execute_rd_wr_data,
    input  logic            execute_mem_rd_en,
    input  logic            execute_mem_wr_en,
    input  logic [2:0]      execute_mem_funct3,
    input  logic [XLEN-1:0] execute_mem_wr_data,
    input  logic            trap_flush,
    output logic            memory_stall,
    output logic            memory_clk_en,
    output logic [4:0]      memory_rd,
    output logic            memory_rd_wr_en,
    output logic [XLEN-1:0] memory_rd_wr_data,
    output logic            memory_rd_valid,
    output logic            memory_misaligned,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            writeback_valid,
    output logic [4:0]      writeback_rd,
    output logic            writeback_rd_wr_en,
    output logic [XLEN-1:0] writeback_rd_wr_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      rd_q;
    logic            rd_wr_en_q;
    logic [XLEN-1:0] result_q;
    logic            mem_rd_en_q;
    logic            mem_wr_en_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] store_data_q;

    logic            hold;
    logic            drain;
    logic            mem_op;
    logic [1:0]      off;
    logic            width_misaligned;
    logic            access_misaligned;
    logic            load_done;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_data;
    logic [3:0]      be_raw;

    assign hold   = (state == ST_HOLD);
    assign drain  = (state == ST_DRAIN);
    assign mem_op = mem_rd_en_q | mem_wr_en_q;
    assign off    = result_q[1:0];

    // Halfword needs an even offset, word needs offset 0; bytes never fault.
    assign width_misaligned  = ((funct3_q[1:0] == 2'b01) & off[0]) |
                               ((funct3_q[1:0] == 2'b10) & (off != 2'b00));
    assign access_misaligned = hold & mem_op & width_misaligned;

    // A drained (flushed) access keeps requesting until the bus answers.
    assign dmem_req     = (hold & mem_op & ~width_misaligned) | drain;
    assign memory_stall = dmem_req & ~dmem_ack;

    assign dmem_we    = dmem_req & mem_wr_en_q;
    assign dmem_addr  = {result_q[XLEN-1:2], 2'b00};
    assign dmem_wdata = store_data_q << {off, 3'b000};
    assign dmem_be    = dmem_req ? be_raw : 4'b0000;

    // Byte-enable pattern: loads fetch the whole word, stores mark their lanes.
    always_comb begin
        be_raw = 4'b1111;
        if (mem_wr_en_q) begin
            case (funct3_q[1:0])
                2'b00:   be_raw = 4'b0001 << off;
                2'b01:   be_raw = 4'b0011 << off;
                default: be_raw = 4'b1111;
            endcase
        end
    end

    assign rdata_shifted = dmem_rdata >> {off, 3'b000};

    // Load extension by funct3; unknown encodings behave as LW.
    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    assign load_done = hold & mem_rd_en_q & ~width_misaligned & dmem_ack;

    assign memory_clk_en     = hold;
    assign memory_rd         = rd_q;
    assign memory_rd_wr_en   = hold & rd_wr_en_q & (rd_q != 5'd0) & ~access_misaligned;
    assign memory_rd_wr_data = load_done ? load_data : result_q;
    assign memory_rd_valid   = hold & (~mem_rd_en_q | access_misaligned | dmem_ack);
    assign memory_misaligned = access_misaligned;

    // Stage FSM: capture from Execute, complete into Writeback, flush/drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= ST_EMPTY;
            rd_q                 <= 5'd0;
            rd_wr_en_q           <= 1'b0;
            result_q             <= '0;
            mem_rd_en_q          <= 1'b0;
            mem_wr_en_q          <= 1'b0;
            funct3_q             <= 3'd0;
            store_data_q         <= '0;
            writeback_valid      <= 1'b0;
            writeback_rd         <= 5'd0;
            writeback_rd_wr_en   <= 1'b0;
            writeback_rd_wr_data <= '0;
        end else begin
            writeback_valid <= 1'b0;
            if (hold && trap_flush) begin
                // Flush beats completion; an outstanding access must still finish.
                state <= memory_stall ? ST_DRAIN : ST_EMPTY;
            end else if (!memory_stall) begin
                if (hold) begin
                    writeback_valid      <= 1'b1;
                    writeback_rd         <= rd_q;
                    writeback_rd_wr_en   <= rd_wr_en_q & ~access_misaligned & (rd_q != 5'd0);
                    writeback_rd_wr_data <= memory_rd_wr_data;
                end
                state        <= execute_valid ? ST_HOLD : ST_EMPTY;
                rd_q         <= execute_rd;
                rd_wr_en_q   <= execute_rd_wr_en;
                result_q     <= execute_rd_wr_data;
                mem_rd_en_q  <= execute_mem_rd_en;
                mem_wr_en_q  <= execute_mem_wr_en;
                funct3_q     <= execute_mem_funct3;
                store_data_q <= execute_mem_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the Memory stage: directed cases, randomized
// single instructions against a spec-level reference, a back-to-back ALU
// stream, flush/drain and reset during a pending access.
module tb_memory;

    logic        clk;
    logic        rst_n;
    logic        execute_valid;
    logic [4:0]  execute_rd;
    logic        execute_rd_wr_en;
    logic [31:0] execute_rd_wr_data;
    logic        execute_mem_rd_en;
    logic        execute_mem_wr_en;
    logic [2:0]  execute_mem_funct3;
    logic [31:0] execute_mem_wr_data;
    logic        trap_flush;
    logic        memory_stall;
    logic        memory_clk_en;
    logic [4:0]  memory_rd;
    logic        memory_rd_wr_en;
    logic [31:0] memory_rd_wr_data;
    logic        memory_rd_valid;
    logic        memory_misaligned;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        writeback_valid;
    logic [4:0]  writeback_rd;
    logic        writeback_rd_wr_en;
    logic [31:0] writeback_rd_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [37:0] exp_q[$];

    memory #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .execute_valid(execute_valid), .execute_rd(execute_rd),
        .execute_rd_wr_en(execute_rd_wr_en), .execute_rd_wr_data(execute_rd_wr_data),
        .execute_mem_rd_en(execute_mem_rd_en), .execute_mem_wr_en(execute_mem_wr_en),
        .execute_mem_funct3(execute_mem_funct3), .execute_mem_wr_data(execute_mem_wr_data),
        .trap_flush(trap_flush), .memory_stall(memory_stall), .memory_clk_en(memory_clk_en),
        .memory_rd(memory_rd), .memory_rd_wr_en(memory_rd_wr_en),
        .memory_rd_wr_data(memory_rd_wr_data), .memory_rd_valid(memory_rd_valid),
        .memory_misaligned(memory_misaligned), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .writeback_valid(writeback_valid), .writeback_rd(writeback_rd),
        .writeback_rd_wr_en(writeback_rd_wr_en), .writeback_rd_wr_data(writeback_rd_wr_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: load extension from the architectural rules, plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * off);
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic st, input logic [2:0] f3, input logic [1:0] off);
        if (!st) return 4'hF;
        case (f3[1:0])
            2'd0:    return 4'(1 << off);
            2'd1:    return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m + (32'hFF << (8 * i));
        return m;
    endfunction

    task automatic set_exec(input logic v, input logic [4:0] rd, input logic wen,
                            input logic [31:0] res, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] sd);
        execute_valid       = v;
        execute_rd          = rd;
        execute_rd_wr_en    = wen;
        execute_rd_wr_data  = res;
        execute_mem_rd_en   = ld;
        execute_mem_wr_en   = st;
        execute_mem_funct3  = f3;
        execute_mem_wr_data = sd;
    endtask

    // One isolated instruction with a bus that acks dly cycles after req rises.
    task automatic run_op(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                          input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] sd, input logic [31:0] rdata, input int dly);
        logic [1:0]  off;
        logic        memop, mis, exp_en, ack_now, done;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        int          wb_at, reqc;
        off      = res[1:0];
        memop    = ld | st;
        mis      = memop && ((f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0));
        exp_en   = wen && !mis && rd != 5'd0;
        exp_data = (ld && !mis) ? ref_load(f3, off, rdata) : res;
        exp_be   = ref_be(st, f3, off);
        wb_at    = (memop && !mis) ? dly : 0;
        @(negedge clk);
        set_exec(1'b1, rd, wen, res, ld, st, f3, sd);
        @(negedge clk);
        set_exec(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        reqc = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            ack_now = 1'b0;
            if (dmem_req) begin
                check("dmem_addr", dmem_addr, {res[31:2], 2'b00});
                check("dmem_we", dmem_we, st);
                check("dmem_be", dmem_be, exp_be);
                if (st) check("dmem_wdata", dmem_wdata & lane_mask(exp_be),
                              (sd << (8 * off)) & lane_mask(exp_be));
                if (reqc == dly) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                    ack_now    = 1'b1;
                end
                reqc++;
            end
            #1;
            check("stall", memory_stall, memop && !mis && !ack_now);
            check("rd_valid", memory_rd_valid, !ld || mis || ack_now);
            if (ack_now && ld) check("fwd_load_data", memory_rd_wr_data, exp_data);
            if (c == 0) begin
                check("clk_en", memory_clk_en, 1);
                check("memory_rd", memory_rd, rd);
                check("misaligned", memory_misaligned, mis);
                check("req_issued", dmem_req, memop && !mis);
                if (!mis) check("fwd_wr_en", memory_rd_wr_en, exp_en);
            end else if (c == 1) begin
                check("misaligned_pulse", memory_misaligned, 0);
            end
            @(posedge clk);
            #1;
            if (writeback_valid) begin
                check("wb_cycle", c, wb_at);
                check("wb_rd", writeback_rd, rd);
                check("wb_wr_en", writeback_rd_wr_en, exp_en);
                if (exp_en) check("wb_data", writeback_rd_wr_data, exp_data);
                done = 1'b1;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        if (!done) check("wb_timeout", 0, 1);
        @(posedge clk);
        #1;
        check("wb_bubble", writeback_valid, 0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wen, ld, st;
        int          kind;
        logic [37:0] e;

        // Reset
        rst_n      = 1'b0;
        trap_flush = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        set_exec(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", writeback_valid, 0);
        check("rst_wb_data", writeback_rd_wr_data, 0);
        check("rst_req", dmem_req, 0);
        check("rst_be", dmem_be, 0);
        check("rst_stall", memory_stall, 0);
        check("rst_clk_en", memory_clk_en, 0);
        check("rst_rd_valid", memory_rd_valid, 0);
        check("rst_misaligned", memory_misaligned, 0);
        rst_n = 1'b1;

        // Directed cases
        run_op(5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 0);
        run_op(5'd7, 1'b1, 32'h1003, 1'b1, 1'b0, 3'd0, 32'd0, 32'h80000000, 2);
        run_op(5'd7, 1'b1, 32'h1003, 1'b1, 1'b0, 3'd4, 32'd0, 32'h80000000, 2);
        run_op(5'd0, 1'b0, 32'h2002, 1'b0, 1'b1, 3'd1, 32'h0000ABCD, 32'd0, 0);
        run_op(5'd8, 1'b1, 32'h1002, 1'b1, 1'b0, 3'd2, 32'd0, 32'h12345678, 0);
        run_op(5'd0, 1'b1, 32'h0000BEEF, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 0);

        // Randomized single instructions
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            rd   = 5'($urandom_range(0, 31));
            ld   = (kind == 1);
            st   = (kind == 2);
            wen  = st ? 1'b0 : (ld ? 1'b1 : 1'($urandom_range(0, 1)));
            if (ld) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end else if (st) f3 = 3'($urandom_range(0, 2));
            else f3 = 3'($urandom_range(0, 7));
            run_op(rd, wen, $urandom, ld, st, f3, $urandom, $urandom, $urandom_range(0, 3));
        end

        // Back-to-back ALU stream: one result per edge
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                rd  = 5'($urandom_range(0, 31));
                wen = 1'($urandom_range(0, 1));
                e   = {rd, wen && rd != 5'd0, 32'($urandom)};
                exp_q.push_back(e);
                set_exec(1'b1, rd, wen, e[31:0], 1'b0, 1'b0, 3'($urandom_range(0, 7)), 32'd0);
            end else begin
                set_exec(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
            end
            @(posedge clk);
            #1;
            if (i >= 1) begin
                e = exp_q.pop_front();
                check("stream_valid", writeback_valid, 1);
                check("stream_rd", writeback_rd, e[37:33]);
                check("stream_wr_en", writeback_rd_wr_en, e[32]);
                check("stream_data", writeback_rd_wr_data, e[31:0]);
            end
        end

        // Flush of a pending LW: drain until ack, next instruction taken on ack edge
        @(negedge clk);
        set_exec(1'b1, 5'd9, 1'b1, 32'h1000, 1'b1, 1'b0, 3'd2, 32'd0);
        @(negedge clk);
        set_exec(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        #1;
        check("fl_req0", dmem_req, 1);
        check("fl_stall0", memory_stall, 1);
        @(posedge clk); #1;
        check("fl_wb0", writeback_valid, 0);
        @(negedge clk);
        trap_flush = 1'b1;
        #1;
        check("fl_stall1", memory_stall, 1);
        @(posedge clk); #1;
        check("fl_wb1", writeback_valid, 0);
        @(negedge clk);
        trap_flush = 1'b0;
        set_exec(1'b1, 5'd11, 1'b1, 32'h55, 1'b0, 1'b0, 3'd0, 32'd0);
        #1;
        check("drain_req", dmem_req, 1);
        check("drain_addr", dmem_addr, 32'h1000);
        check("drain_stall", memory_stall, 1);
        check("drain_clk_en", memory_clk_en, 0);
        check("drain_rd_valid", memory_rd_valid, 0);
        @(posedge clk); #1;
        check("fl_wb2", writeback_valid, 0);
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = $urandom;
        #1;
        check("drain_ack_req", dmem_req, 1);
        check("drain_ack_stall", memory_stall, 0);
        @(posedge clk); #1;
        check("fl_wb3", writeback_valid, 0);
        @(negedge clk);
        dmem_ack = 1'b0;
        set_exec(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        #1;
        check("after_drain_clk_en", memory_clk_en, 1);
        check("after_drain_rd", memory_rd, 11);
        check("after_drain_req", dmem_req, 0);
        @(posedge clk); #1;
        check("after_drain_wb_valid", writeback_valid, 1);
        check("after_drain_wb_rd", writeback_rd, 11);
        check("after_drain_wb_data", writeback_rd_wr_data, 32'h55);

        // Flush of a non-stalled ALU op: no writeback, next Execute op not captured
        @(negedge clk);
        set_exec(1'b1, 5'd12, 1'b1, 32'h77, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk);
        set_exec(1'b1, 5'd13, 1'b1, 32'h88, 1'b0, 1'b0, 3'd0, 32'd0);
        trap_flush = 1'b1;
        @(posedge clk); #1;
        check("flush_alu_wb", writeback_valid, 0);
        @(negedge clk);
        trap_flush = 1'b0;
        set_exec(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        check("flush_alu_not_captured", memory_clk_en, 0);
        @(posedge clk); #1;
        check("flush_alu_wb2", writeback_valid, 0);

        // Reset during a pending load
        @(negedge clk);
        set_exec(1'b1, 5'd4, 1'b1, 32'h3000, 1'b1, 1'b0, 3'd2, 32'd0);
        @(negedge clk);
        set_exec(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        check("rst_pend_req", dmem_req, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_pend_req_clr", dmem_req, 0);
        check("rst_pend_stall", memory_stall, 0);
        check("rst_pend_clk_en", memory_clk_en, 0);
        check("rst_pend_wb", writeback_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Memory stage of the RV32I 5-stage pipeline. Sits between Execute and Writeback.
- Registers the Execute result and performs loads/stores over a req/ack data bus, with byte/half alignment and sign extension.
- Stalls upstream while a bus access is pending.
- Presents its held rd/result as the Memory/Writeback forwarding source and registers the completed result into the Writeback stage.

Parameters:
- XLEN, 32, data/address width (only 32 is supported).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- execute_valid  input  1  Execute presents a valid instruction this cycle
- execute_rd  input  5  destination register
- execute_rd_wr_en  input  1  instruction writes rd
- execute_rd_wr_data  input  32  ALU result; this is the effective address for load/store
- execute_mem_rd_en  input  1  instruction is a load
- execute_mem_wr_en  input  1  instruction is a store
- execute_mem_funct3  input  3  load/store width and signedness (RV32I funct3)
- execute_mem_wr_data  input  32  store data (rs2)
- trap_flush  input  1  kill the instruction held in Memory
- memory_stall  output  1  stall Execute and earlier stages
- memory_clk_en  output  1  Memory stage holds a live instruction
- memory_rd  output  5  held rd, for forwarding
- memory_rd_wr_en  output  1  held instruction writes rd; forced 0 when rd==0
- memory_rd_wr_data  output  32  held result: ALU result, or load data once acked
- memory_rd_valid  output  1  memory_rd_wr_data is final this cycle
- memory_misaligned  output  1  one-cycle pulse: misaligned access dropped
- dmem_req  output  1  bus request
- dmem_we  output  1  1 = store, 0 = load
- dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  store data shifted into lane position
- dmem_ack  input  1  access complete (may arrive in the same cycle as req)
- dmem_rdata  input  32  load word, valid when ack
- writeback_valid  output  1  registered: Writeback holds a completed instruction
- writeback_rd  output  5  registered rd
- writeback_rd_wr_en  output  1  registered write enable
- writeback_rd_wr_data  output  32  registered result

Behaviour:
- Reset (rst_n low at an edge): FSM goes to EMPTY and all stage and writeback registers clear. Every output is 0 except the pure pass-through combinational outputs, which are 0 as a consequence.
- FSM states:
  - EMPTY: no instruction held.
  - HOLD: instruction held.
  - DRAIN: flushed instruction with a bus access still outstanding.
- Accept: at any edge where memory_stall=0, the stage captures the Execute inputs.
  - execute_valid=1 -> HOLD, else EMPTY.
  - memory_clk_en = (state==HOLD).
- Access decode (combinational, from held regs): mem_op = rd_en|wr_en; off = addr[1:0].
- Misaligned:
  - funct3[1:0]==01 with off[0]=1, or funct3[1:0]==10 with off!=0.
  - No dmem_req is issued; memory_misaligned=1 during the HOLD cycle.
  - The instruction completes with writeback_rd_wr_en=0.
- Request: dmem_req = (HOLD & mem_op & !misaligned) | DRAIN. Address, we, be and wdata stay stable while req is high. req is held until ack and is never withdrawn.
- memory_stall = dmem_req & !dmem_ack, so a same-cycle ack gives a zero-bubble access.
- Byte enables:
  - Loads: be=1111.
  - SB: 0001<<off. SH: 0011<<off. SW: 1111.
  - wdata = store data << (8*off); unused lanes are don't-care.
- Load data:
  - Formed from dmem_rdata >> (8*off).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
  - Any other funct3 is treated as LW.
- memory_rd_valid:
  - 1 for non-memory ops and stores.
  - 1 for loads only in the ack cycle, with memory_rd_wr_data then equal to the extended load data.
  - 0 when EMPTY or DRAIN.
- Completion: at an edge in HOLD with memory_stall=0, the writeback regs load {1, rd, rd_wr_en & !misaligned & rd!=0, result}. Otherwise at every edge writeback_valid<=0 (a bubble).
- Latency: non-memory ops reach Writeback one edge after capture. Loads and stores take ack_cycle+1.
- Flush: trap_flush at an edge with state HOLD:
  - If dmem_req & !ack -> DRAIN, with no writeback.
  - Otherwise -> EMPTY, with writeback_valid<=0 and the next Execute instruction not captured.
- DRAIN: req held, stall=1. On ack -> EMPTY with no writeback. trap_flush while in EMPTY or DRAIN has no further effect.
- Flush wins over completion at the same edge.

Test Plan:
- ALU op: execute_valid=1, rd=5, wr_en=1, data=0x1234 -> next cycle memory_clk_en=1, memory_rd=5, rd_valid=1, stall=0. Following edge: writeback rd=5, data=0x00001234, valid=1.
- LB, addr=0x1003, rdata=0x80000000, ack 2 cycles after req -> dmem_addr=0x1000, be=1111, we=0, stall high 2 cycles, writeback data=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH, addr=0x2002, store data=0x0000ABCD, same-cycle ack -> be=1100, wdata[31:16]=0xABCD, we=1, no stall cycle, writeback_rd_wr_en=0.
- LW, addr=0x1002 -> memory_misaligned pulse for 1 cycle, dmem_req never asserted, writeback_valid=1 with rd_wr_en=0.
- LW pending with ack delayed 3 cycles, trap_flush on cycle 1 -> req held until ack, stall high throughout, no writeback_valid. The next instruction is accepted on the ack edge.
- rst_n low during a pending load -> next edge: dmem_req=0, stall=0, memory_clk_en=0, writeback_valid=0.
